// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
// Requester ids double as bit positions in the two-bit request/grant vectors.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner selection for the IF/LS arbiter, zero latency, one-hot grant out.
// MEM_ARB_RR_EN: ties alternate against the last grant; otherwise LS beats IF.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  req_id_e    last_gnt,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_LS] && req[REQ_IF]) begin
`ifdef MEM_ARB_RR_EN
      if (last_gnt == REQ_LS) begin
        gnt[REQ_IF] = 1'b1;
      end else begin
        gnt[REQ_LS] = 1'b1;
      end
`else
      gnt[REQ_LS] = 1'b1;
`endif
    end else begin
      // A lone requester always wins, whatever the pointer says.
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between IF and LS; grant is combinational, completion MEM_LAT+1 cycles later.
// One transaction outstanding, requests stall (no gnt) while busy; MEM_ARB_RR_EN selects round-robin ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [3:0]        i_ls_be,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  req_id_e          owner;
  logic             owner_we;
`ifdef MEM_ARB_RR_EN
  req_id_e          last_gnt;
`endif

  logic [1:0] req_vec;
  logic [1:0] pick;
  logic [1:0] gnt_vec;
  logic       can_grant;

  assign req_vec = {i_ls_req, i_if_req};

  arb_pick u_arb_pick (
    .req      (req_vec),
`ifdef MEM_ARB_RR_EN
    .last_gnt (last_gnt),
`endif
    .gnt      (pick)
  );

  // Gated with reset so nothing is granted while the block is held in reset.
  assign can_grant = (state == IDLE) && i_reset;
  assign gnt_vec   = can_grant ? pick : 2'b00;

  assign o_if_gnt  = gnt_vec[REQ_IF];
  assign o_ls_gnt  = gnt_vec[REQ_LS];
  assign o_mem_req = |gnt_vec;
  assign o_busy    = (state == WAIT);

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = 4'h0;
    if (gnt_vec[REQ_LS]) begin
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_be    = i_ls_be;
    end else if (gnt_vec[REQ_IF]) begin
      o_mem_addr  = i_if_addr;
      o_mem_be    = BE_FULL;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= REQ_IF;
      owner_we    <= 1'b0;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_rvalid <= 1'b0;
      o_ls_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      last_gnt    <= REQ_IF;
`endif
    end else begin
      o_if_rvalid <= 1'b0;
      o_ls_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt_vec) begin
            owner    <= gnt_vec[REQ_LS] ? REQ_LS : REQ_IF;
            owner_we <= gnt_vec[REQ_LS] & i_ls_we;
            cnt      <= CNT_W'(MEM_LAT - 1);
            state    <= WAIT;
`ifdef MEM_ARB_RR_EN
            last_gnt <= gnt_vec[REQ_LS] ? REQ_LS : REQ_IF;
`endif
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Memory data is valid in this cycle; capture it for the owner.
            state <= IDLE;
            if (owner == REQ_LS) begin
              o_ls_rvalid <= 1'b1;
              o_ls_rdata  <= owner_we ? '0 : i_mem_rdata;
            end else begin
              o_if_rvalid <= 1'b1;
              o_if_rdata  <= i_mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) on shared stimulus, checked each cycle
// against a timeline model (grant cycle, free cycle, completion cycle) plus directed literal checks.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared DUT inputs
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic [31:0] mem_rdata [2];

  // Per-DUT outputs (index 0: MEM_LAT=1, index 1: MEM_LAT=3)
  logic [1:0]  if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy;
  logic [31:0] if_rdata [2];
  logic [31:0] ls_rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_be [2];

  // Staged inputs, applied just after each rising edge
  logic        s_rst = 1'b0, s_if_req = 1'b0, s_ls_req = 1'b0, s_ls_we = 1'b0;
  logic [31:0] s_if_addr = '0, s_ls_addr = '0, s_ls_wdata = '0;
  logic [3:0]  s_ls_be = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Memory responder bookkeeping (driven from DUT memory port)
  int          rq_cyc [2] = '{-100, -100};
  logic [31:0] rq_addr [2];

  // Timeline model
  int          m_free_at [2];
  int          m_comp_at [2];
  bit          m_comp_ls [2];
  logic [31:0] m_comp_data [2];
  logic [31:0] m_hold_if [2];
  logic [31:0] m_hold_ls [2];
`ifdef MEM_ARB_RR_EN
  bit          m_last_ls [2];
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt[0]),
    .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_be(ls_be), .o_ls_gnt(ls_gnt[0]), .o_ls_rvalid(ls_rvalid[0]), .o_ls_rdata(ls_rdata[0]),
    .o_mem_req(mem_req[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .o_mem_be(mem_be[0]), .i_mem_rdata(mem_rdata[0]),
    .o_busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt[1]),
    .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_be(ls_be), .o_ls_gnt(ls_gnt[1]), .o_ls_rvalid(ls_rvalid[1]), .o_ls_rdata(ls_rdata[1]),
    .o_mem_req(mem_req[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .o_mem_be(mem_be[1]), .i_mem_rdata(mem_rdata[1]),
    .o_busy(busy[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Memory contents: fixed function of address, one pinned word.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic model_and_compare();
    for (int d = 0; d < 2; d++) begin
      logic        e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_req, e_we, e_busy, win_ls;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0; e_req = 0; e_we = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0; e_be = '0; win_ls = 0;
      if (!rst_n) begin
        m_free_at[d] = cyc;
        m_comp_at[d] = -1;
        m_hold_if[d] = '0;
        m_hold_ls[d] = '0;
`ifdef MEM_ARB_RR_EN
        m_last_ls[d] = 1'b0;
`endif
      end else begin
        if (m_comp_at[d] == cyc) begin
          if (m_comp_ls[d]) begin e_ls_rv = 1; m_hold_ls[d] = m_comp_data[d]; end
          else begin e_if_rv = 1; m_hold_if[d] = m_comp_data[d]; end
        end
        if (cyc >= m_free_at[d]) begin
`ifdef MEM_ARB_RR_EN
          win_ls = (ls_req && if_req) ? !m_last_ls[d] : ls_req;
`else
          win_ls = ls_req;
`endif
          if (ls_req || if_req) begin
            e_req = 1;
            if (win_ls) begin
              e_ls_gnt = 1; e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata; e_be = ls_be;
            end else begin
              e_if_gnt = 1; e_addr = if_addr; e_be = 4'hF;
            end
            m_free_at[d]   = cyc + lat(d) + 1;
            m_comp_at[d]   = cyc + lat(d) + 1;
            m_comp_ls[d]   = win_ls;
            m_comp_data[d] = (win_ls && ls_we) ? 32'h0 : mem_val(e_addr);
`ifdef MEM_ARB_RR_EN
            m_last_ls[d] = win_ls;
`endif
          end
        end else begin
          e_busy = 1;
        end
      end
      chk("if_gnt", d, 32'(if_gnt[d]), 32'(e_if_gnt));
      chk("ls_gnt", d, 32'(ls_gnt[d]), 32'(e_ls_gnt));
      chk("if_rvalid", d, 32'(if_rvalid[d]), 32'(e_if_rv));
      chk("ls_rvalid", d, 32'(ls_rvalid[d]), 32'(e_ls_rv));
      chk("if_rdata", d, if_rdata[d], m_hold_if[d]);
      chk("ls_rdata", d, ls_rdata[d], m_hold_ls[d]);
      chk("mem_req", d, 32'(mem_req[d]), 32'(e_req));
      chk("mem_we", d, 32'(mem_we[d]), 32'(e_we));
      chk("mem_addr", d, mem_addr[d], e_addr);
      chk("mem_wdata", d, mem_wdata[d], e_wdata);
      chk("mem_be", d, 32'(mem_be[d]), 32'(e_be));
      chk("busy", d, 32'(busy[d]), 32'(e_busy));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = s_rst; if_req = s_if_req; if_addr = s_if_addr;
    ls_req = s_ls_req; ls_we = s_ls_we; ls_addr = s_ls_addr; ls_wdata = s_ls_wdata; ls_be = s_ls_be;
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (rq_cyc[d] + lat(d) == cyc) ? mem_val(rq_addr[d]) : $urandom;
    @(negedge clk);
    model_and_compare();
    for (int d = 0; d < 2; d++)
      if (mem_req[d]) begin rq_cyc[d] = cyc; rq_addr[d] = mem_addr[d]; end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gcount, bcount, last_g;
    mem_rdata[0] = '0;
    mem_rdata[1] = '0;
    // Reset with a request pending: nothing may be granted
    s_rst = 0; s_if_req = 1; s_if_addr = 32'h44;
    steps(3);
    chk("rst_if_gnt", 0, 32'(if_gnt[0]), 32'h0);
    chk("rst_mem_req", 0, 32'(mem_req[0]), 32'h0);
    s_rst = 1; s_if_req = 0;
    steps(2);

    // IF read alone, MEM_LAT=1
    s_if_req = 1; s_if_addr = 32'h0000_0010;
    step();
    chk("A_if_gnt", 0, 32'(if_gnt[0]), 32'h1);
    chk("A_mem_req", 0, 32'(mem_req[0]), 32'h1);
    chk("A_mem_we", 0, 32'(mem_we[0]), 32'h0);
    chk("A_mem_be", 0, 32'(mem_be[0]), 32'hF);
    s_if_req = 0;
    step();
    chk("A_busy", 0, 32'(busy[0]), 32'h1);
    chk("A_no_early_rvalid", 0, 32'(if_rvalid[0]), 32'h0);
    step();
    chk("A_rvalid", 0, 32'(if_rvalid[0]), 32'h1);
    chk("A_rdata", 0, if_rdata[0], 32'hDEAD_BEEF);
    step();
    chk("A_rvalid_pulse", 0, 32'(if_rvalid[0]), 32'h0);
    chk("A_rdata_hold", 0, if_rdata[0], 32'hDEAD_BEEF);
    steps(3);

    // Simultaneous requests: LS first, IF granted in the LS completion cycle
    s_if_req = 1; s_if_addr = 32'h20; s_ls_req = 1; s_ls_we = 0; s_ls_addr = 32'h30; s_ls_be = 4'hF;
    step();
    chk("B_ls_gnt", 0, 32'(ls_gnt[0]), 32'h1);
    chk("B_if_no_gnt", 0, 32'(if_gnt[0]), 32'h0);
    s_ls_req = 0;
    step();
    step();
    chk("B_if_gnt", 0, 32'(if_gnt[0]), 32'h1);
    chk("B_ls_rvalid", 0, 32'(ls_rvalid[0]), 32'h1);
    s_if_req = 0;
    step();
    step();
    chk("B_if_rvalid", 0, 32'(if_rvalid[0]), 32'h1);
    chk("B_if_rdata", 0, if_rdata[0], 32'h5A7A_C3C3);
    steps(4);

    // LS write: payload passes through, completion carries zero data
    s_ls_req = 1; s_ls_we = 1; s_ls_addr = 32'h1000_0004; s_ls_wdata = 32'h1234_5678; s_ls_be = 4'b0011;
    step();
    chk("C_mem_we", 0, 32'(mem_we[0]), 32'h1);
    chk("C_mem_be", 0, 32'(mem_be[0]), 32'h3);
    chk("C_mem_addr", 0, mem_addr[0], 32'h1000_0004);
    chk("C_mem_wdata", 0, mem_wdata[0], 32'h1234_5678);
    s_ls_req = 0; s_ls_we = 0;
    steps(2);
    chk("C_ls_rvalid", 0, 32'(ls_rvalid[0]), 32'h1);
    chk("C_ls_rdata", 0, ls_rdata[0], 32'h0);
    chk("C_if_rvalid", 0, 32'(if_rvalid[0]), 32'h0);
    steps(3);

    // Back-to-back IF on the MEM_LAT=3 instance
    s_if_req = 1; s_if_addr = 32'h40;
    gcount = 0; bcount = 0; last_g = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if_gnt[1]) begin
        if (last_g >= 0) chk("D_gnt_spacing", 1, 32'(cyc - last_g), 32'd4);
        last_g = cyc;
        gcount++;
      end
      if (busy[1]) bcount++;
    end
    chk("D_gnt_count", 1, 32'(gcount), 32'd3);
    chk("D_busy_cycles", 1, 32'(bcount), 32'd9);
    s_if_req = 0;
    steps(5);

    // Continuous contention on the MEM_LAT=1 instance; last grant before this was IF
    s_if_req = 1; s_if_addr = 32'h60; s_ls_req = 1; s_ls_we = 0; s_ls_addr = 32'h70; s_ls_be = 4'hF;
    gcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ls_gnt[0] || if_gnt[0]) begin
`ifdef MEM_ARB_RR_EN
        chk("E_order_ls", 0, 32'(ls_gnt[0]), 32'((gcount % 2) == 0));
`else
        chk("E_order_ls", 0, 32'(ls_gnt[0]), 32'h1);
`endif
        gcount++;
      end
    end
    chk("E_gnt_count", 0, 32'(gcount), 32'd6);
    s_if_req = 0; s_ls_req = 0;
    steps(5);

    // Reset during WAIT aborts the transaction
    s_if_req = 1; s_if_addr = 32'h50;
    step();
    s_if_req = 0; s_rst = 0;
    step();
    chk("F_busy", 0, 32'(busy[0]), 32'h0);
    chk("F_rvalid", 0, 32'(if_rvalid[0]), 32'h0);
    chk("F_rdata", 0, if_rdata[0], 32'h0);
    step();
    s_rst = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("F_no_rvalid", 0, 32'(if_rvalid[0]), 32'h0);
    end
    s_if_req = 1; s_if_addr = 32'h10;
    step();
    s_if_req = 0;
    steps(2);
    chk("F_fresh_rvalid", 0, 32'(if_rvalid[0]), 32'h1);
    chk("F_fresh_rdata", 0, if_rdata[0], 32'hDEAD_BEEF);
    steps(3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      s_rst      = ($urandom_range(0, 149) != 0);
      s_if_req   = ($urandom_range(0, 2) != 0);
      s_ls_req   = ($urandom_range(0, 2) != 0);
      s_ls_we    = $urandom_range(0, 1);
      s_if_addr  = $urandom;
      s_ls_addr  = $urandom;
      s_ls_wdata = $urandom;
      s_ls_be    = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
